pq_cmd_sched: RTL and testbench

//  Upstream command front-end for the heap priority queue. Buffers client ENQ/DEQ/REPLACE

---
 rtl/pq_cmd_sched.sv | 209 ++++++++++++++++++++
 tb/tb_pq_cmd_sched.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pq_cmd_sched.sv
// ---------------------------------------------------------------------------
// pq_cmd_sched
//
// Command front-end for the heap priority queue. Client ENQ / DEQ / REPLACE
// commands are buffered in a small FIFO and issued to the PQ one at a time,
// never while the PQ is busy, and never as an illegal operation (ENQ into a
// full PQ, DEQ/REPLACE from an empty PQ). Every accepted command produces
// exactly one response, in command order, through a valid/ready channel.
//
// Optional feature macro: PQ_SCHED_STATS_EN
//   defined   : stat_enq / stat_deq / stat_err are saturating 16-bit counters
//   undefined : stat_* are tied to zero and no counter flops exist
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cmd_valid/ready     client command handshake (ready = FIFO not full)
//   cmd_op              01 ENQ, 10 DEQ, 11 REPLACE, 00 NOP
//   cmd_kv              {key,val} for ENQ / REPLACE
//   rsp_valid/ready     response handshake
//   rsp_kv              removed head for DEQ / REPLACE, else 0
//   rsp_err             command rejected by the full/empty check
//   pq_enq, pq_deq      one-cycle strobes to the PQ (both = replace)
//   pq_kvi              pair to insert, non-zero only while pq_enq is high
//   pq_kvo              current PQ head (minimum key)
//   pq_busy/full/empty  PQ status
//   stat_enq/deq/err    operation counters
// ---------------------------------------------------------------------------
module pq_cmd_sched #(
  parameter int KW        = 16,
  parameter int VW        = 16,
  parameter int CMD_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [KW+VW-1:0] cmd_kv,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [KW+VW-1:0] rsp_kv,
  output logic             rsp_err,
  output logic             pq_enq,
  output logic             pq_deq,
  output logic [KW+VW-1:0] pq_kvi,
  input  logic [KW+VW-1:0] pq_kvo,
  input  logic             pq_busy,
  input  logic             pq_full,
  input  logic             pq_empty,
  output logic [15:0]      stat_enq,
  output logic [15:0]      stat_deq,
  output logic [15:0]      stat_err
);

  localparam int KVW = KW + VW;
  localparam int AW  = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;

  localparam logic [1:0] OP_ENQ = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t         state;

  // -------------------------------------------------------------------------
  // Command FIFO. Pointers carry one extra wrap bit so full and empty are
  // distinguishable without a separate count.
  // -------------------------------------------------------------------------
  logic [KVW-1:0] fifo_kv [CMD_DEPTH];
  logic [1:0]     fifo_op [CMD_DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           fifo_empty;
  logic           fifo_full;
  logic           push;
  logic           pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // No bypass: readiness depends only on occupancy, not on a same-cycle pop.
  assign cmd_ready = !fifo_full && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == S_IDLE) && !fifo_empty && !pq_busy;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_kv[wr_ptr[AW-1:0]] <= cmd_kv;
      fifo_op[wr_ptr[AW-1:0]] <= cmd_op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // -------------------------------------------------------------------------
  // Issue decode. The legality check uses the PQ status seen in the ISSUE
  // cycle itself; if the PQ unexpectedly reports busy there, the FSM holds
  // in ISSUE so a strobe is never driven into a busy PQ.
  // -------------------------------------------------------------------------
  logic [1:0]     cur_op;
  logic [KVW-1:0] cur_kv;
  logic [KVW-1:0] rsp_kv_r;
  logic           rsp_err_r;
  logic           issue_go;
  logic           issue_err;

  assign issue_go  = (state == S_ISSUE) && !pq_busy;
  assign issue_err = ((cur_op == OP_ENQ) && pq_full) ||
                     (cur_op[1] && pq_empty);

  assign pq_enq = issue_go && !issue_err && cur_op[0];
  assign pq_deq = issue_go && !issue_err && cur_op[1];
  assign pq_kvi = pq_enq ? cur_kv : '0;

  // -------------------------------------------------------------------------
  // Scheduler FSM: IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE.
  // Data registers are loaded without reset; only state and the error flag
  // are reset, and the response outputs are qualified by RESP below.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (pop) begin
      cur_op <= fifo_op[rd_ptr[AW-1:0]];
      cur_kv <= fifo_kv[rd_ptr[AW-1:0]];
    end
    if (issue_go) begin
      rsp_kv_r <= (!issue_err && cur_op[1]) ? pq_kvo : '0;
    end

    if (rst) begin
      state     <= S_IDLE;
      rsp_err_r <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pop) state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (issue_go) begin
            rsp_err_r <= issue_err;
            state     <= issue_err ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          // Entered one cycle after the strobe, so the minimum of one WAIT
          // cycle is implicit; leave once the PQ reports idle.
          if (!pq_busy) state <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = (state == S_RESP);
  assign rsp_kv    = rsp_valid ? rsp_kv_r : '0;
  assign rsp_err   = rsp_valid && rsp_err_r;

  // -------------------------------------------------------------------------
  // Statistics, counted in the cycle the command is issued (or rejected).
  // -------------------------------------------------------------------------
`ifdef PQ_SCHED_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  logic [15:0] cnt_enq;
  logic [15:0] cnt_deq;
  logic [15:0] cnt_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_enq <= '0;
      cnt_deq <= '0;
      cnt_err <= '0;
    end else if (issue_go) begin
      if (issue_err) begin
        cnt_err <= sat_inc(cnt_err);
      end else begin
        if (cur_op[0]) cnt_enq <= sat_inc(cnt_enq);
        if (cur_op[1]) cnt_deq <= sat_inc(cnt_deq);
      end
    end
  end

  assign stat_enq = cnt_enq;
  assign stat_deq = cnt_deq;
  assign stat_err = cnt_err;
`else
  assign stat_enq = '0;
  assign stat_deq = '0;
  assign stat_err = '0;
`endif

endmodule

// File: tb/tb_pq_cmd_sched.sv
// ---------------------------------------------------------------------------
// tb_pq_cmd_sched
//
// Bench for pq_cmd_sched. A small behavioural priority queue (capacity 4,
// busy for two cycles after each operation) sits on the PQ side. Directed
// commands push their hand-computed responses into a scoreboard queue; a
// separate monitor pops and compares on every response handshake.
// ---------------------------------------------------------------------------
module tb_pq_cmd_sched;

  localparam int KW       = 8;
  localparam int VW       = 8;
  localparam int KVW      = KW + VW;
  localparam int DEPTH    = 4;
  localparam int PQ_CAP   = 4;
  localparam int BUSY_CYC = 2;

`ifdef PQ_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_op;
  logic [KVW-1:0] cmd_kv;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [KVW-1:0] rsp_kv;
  logic           rsp_err;
  logic           pq_enq;
  logic           pq_deq;
  logic [KVW-1:0] pq_kvi;
  logic [KVW-1:0] pq_kvo;
  logic           pq_busy;
  logic           pq_full;
  logic           pq_empty;
  logic [15:0]    stat_enq;
  logic [15:0]    stat_deq;
  logic [15:0]    stat_err;

  always #5 clk = ~clk;

  pq_cmd_sched #(.KW(KW), .VW(VW), .CMD_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_kv(cmd_kv),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_kv(rsp_kv), .rsp_err(rsp_err),
    .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_kvi(pq_kvi), .pq_kvo(pq_kvo),
    .pq_busy(pq_busy), .pq_full(pq_full), .pq_empty(pq_empty),
    .stat_enq(stat_enq), .stat_deq(stat_deq), .stat_err(stat_err)
  );

  // Behavioural priority queue
  logic [KVW-1:0] pq_mem [PQ_CAP];
  int             pq_cnt;
  int             busy_cnt;
  int             min_idx;

  assign pq_busy  = (busy_cnt != 0);
  assign pq_full  = (pq_cnt == PQ_CAP);
  assign pq_empty = (pq_cnt == 0);
  assign pq_kvo   = (pq_cnt > 0) ? pq_mem[min_idx] : '0;

  always_comb begin
    min_idx = 0;
    for (int i = 1; i < PQ_CAP; i++)
      if (i < pq_cnt && pq_mem[i][KVW-1:VW] < pq_mem[min_idx][KVW-1:VW]) min_idx = i;
  end

  always @(posedge clk) begin
    if (rst) begin
      pq_cnt   <= 0;
      busy_cnt <= 0;
    end else begin
      if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
      if ((pq_enq || pq_deq) && !pq_busy) begin
        busy_cnt <= BUSY_CYC;
        if (pq_enq && pq_deq) begin
          pq_mem[min_idx] <= pq_kvi;
        end else if (pq_deq && pq_cnt > 0) begin
          pq_mem[min_idx] <= pq_mem[pq_cnt-1];
          pq_cnt          <= pq_cnt - 1;
        end else if (pq_enq && pq_cnt < PQ_CAP) begin
          pq_mem[pq_cnt] <= pq_kvi;
          pq_cnt         <= pq_cnt + 1;
        end
      end
    end
  end

  // Scoreboard and counters
  typedef struct packed {
    logic           err;
    logic [KVW-1:0] kv;
  } rsp_t;

  rsp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_enq_pulse = 0;
  int   n_deq_pulse = 0;
  int   viol = 0;
  int   e_enq = 0;
  int   e_deq = 0;
  int   e_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [KVW-1:0] mk(input logic [7:0] k);
    return {k, k ^ 8'hA5};
  endfunction

  // Response monitor
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_rsp: got err=%0b kv=%0h expected no response", rsp_err, rsp_kv);
        end else begin
          e = sb.pop_front();
          check("rsp", 32'({rsp_err, rsp_kv}), 32'({e.err, e.kv}));
        end
      end
    end
  end

  // Strobe monitor: pulse counts, no strobe into a busy PQ, no held strobe
  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if ((pq_enq || pq_deq) && pq_busy) viol++;
      if ((pq_enq || pq_deq) && prev) viol++;
      prev = pq_enq || pq_deq;
      if (pq_enq) n_enq_pulse++;
      if (pq_deq) n_deq_pulse++;
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [1:0] op, input logic [7:0] key, input bit exp_err,
                      input logic [KVW-1:0] exp_kv, input bit track);
    int t = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_kv    = mk(key);
    while (!cmd_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      n_checks++;
      $display("FAIL send_timeout: got cmd_ready=0 for 300 cycles expected 1");
    end else if (track) begin
      sb.push_back('{err: exp_err, kv: exp_kv});
      if (exp_err) e_err++;
      else begin
        if (op[0]) e_enq++;
        if (op[1]) e_deq++;
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    repeat (8) @(negedge clk);
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_stat_enq"}, 32'(stat_enq), STATS ? 32'(e_enq) : 32'd0);
    check({tag, "_stat_deq"}, 32'(stat_deq), STATS ? 32'(e_deq) : 32'd0);
    check({tag, "_stat_err"}, 32'(stat_err), STATS ? 32'(e_err) : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  localparam logic [1:0] ENQ = 2'b01;
  localparam logic [1:0] DEQ = 2'b10;
  localparam logic [1:0] REP = 2'b11;
  localparam logic [1:0] NOP = 2'b00;

  initial begin
    int p0;
    int t;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_kv    = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_strobes", 32'({pq_enq, pq_deq}), 32'd0);
    check_stats("rst");
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // 1: ENQ 5,2,9 then DEQ x3 -> 2,5,9
    send(ENQ, 8'd5, 1'b0, '0, 1'b1);
    send(ENQ, 8'd2, 1'b0, '0, 1'b1);
    send(ENQ, 8'd9, 1'b0, '0, 1'b1);
    send(DEQ, 8'd0, 1'b0, mk(8'd2), 1'b1);
    send(DEQ, 8'd0, 1'b0, mk(8'd5), 1'b1);
    send(DEQ, 8'd0, 1'b0, mk(8'd9), 1'b1);
    drain();

    // 2: DEQ on empty PQ -> error, no pq_deq pulse
    p0 = n_deq_pulse;
    send(DEQ, 8'd0, 1'b1, '0, 1'b1);
    drain();
    check("empty_deq_no_pulse", 32'(n_deq_pulse - p0), 32'd0);
    check_stats("t2");

    // NOP: acknowledged with no strobe
    p0 = n_enq_pulse + n_deq_pulse;
    send(NOP, 8'd77, 1'b0, '0, 1'b1);
    drain();
    check("nop_no_pulse", 32'(n_enq_pulse + n_deq_pulse - p0), 32'd0);

    // 3: fill PQ, ENQ when full -> error, contents unchanged
    send(ENQ, 8'd40, 1'b0, '0, 1'b1);
    send(ENQ, 8'd10, 1'b0, '0, 1'b1);
    send(ENQ, 8'd30, 1'b0, '0, 1'b1);
    send(ENQ, 8'd20, 1'b0, '0, 1'b1);
    drain();
    p0 = n_enq_pulse;
    send(ENQ, 8'd50, 1'b1, '0, 1'b1);
    drain();
    check("full_enq_no_pulse", 32'(n_enq_pulse - p0), 32'd0);
    send(DEQ, 8'd0, 1'b0, mk(8'd10), 1'b1);
    send(DEQ, 8'd0, 1'b0, mk(8'd20), 1'b1);
    send(DEQ, 8'd0, 1'b0, mk(8'd30), 1'b1);
    send(DEQ, 8'd0, 1'b0, mk(8'd40), 1'b1);
    drain();

    // 4: PQ {3,7}; REPLACE 1 -> 3; DEQ -> 1; DEQ -> 7
    send(ENQ, 8'd3, 1'b0, '0, 1'b1);
    send(ENQ, 8'd7, 1'b0, '0, 1'b1);
    send(REP, 8'd1, 1'b0, mk(8'd3), 1'b1);
    send(DEQ, 8'd0, 1'b0, mk(8'd1), 1'b1);
    send(DEQ, 8'd0, 1'b0, mk(8'd7), 1'b1);
    drain();
    check_stats("t4");

    // 5: backpressure; cmd_ready drops after 5 pushes
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    send(ENQ, 8'd4, 1'b0, '0, 1'b1);
    send(ENQ, 8'd6, 1'b0, '0, 1'b1);
    send(ENQ, 8'd1, 1'b0, '0, 1'b1);
    send(DEQ, 8'd0, 1'b0, mk(8'd1), 1'b1);
    send(DEQ, 8'd0, 1'b0, mk(8'd4), 1'b1);
    check("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
    repeat (6) @(negedge clk);
    check("bp_cmd_ready_held", 32'(cmd_ready), 32'd0);
    check("bp_rsp_valid_held", 32'(rsp_valid), 32'd1);
    check("bp_rsp_stable", 32'({rsp_err, rsp_kv}), 32'd0);
    check("bp_sb_pending", 32'(sb.size()), 32'd5);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    send(DEQ, 8'd0, 1'b0, mk(8'd6), 1'b1);
    drain();
    check_stats("t5");

    // 6: reset during WAIT of a DEQ -> no response, clean restart
    send(ENQ, 8'd8, 1'b0, '0, 1'b1);
    drain();
    send(DEQ, 8'd0, 1'b0, '0, 1'b0);
    t = 0;
    while (!pq_deq && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("t6_deq_strobe_seen", 32'(pq_deq), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    e_enq = 0;
    e_deq = 0;
    e_err = 0;
    @(negedge clk);
    check("t6_post_cmd_ready", 32'(cmd_ready), 32'd1);
    check("t6_post_rsp_valid", 32'(rsp_valid), 32'd0);
    check_stats("t6");
    repeat (10) @(negedge clk);
    check("t6_no_rsp", 32'(rsp_valid), 32'd0);

    // Restart after reset
    send(ENQ, 8'd5, 1'b0, '0, 1'b1);
    send(DEQ, 8'd0, 1'b0, mk(8'd5), 1'b1);
    drain();
    check_stats("end");
    check("strobe_rules", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
